sbox_share_ctrl: RTL and testbench

Time-multiplexes a small bank of NUM_SBOX combinational AES S-box lanes between two requesters. The requesters are the round datapath (SubBytes on the 128-bit state) and the key expansion unit (SubWord on a 32-bit word). Jobs are arbitrated round-robin at job granularity and run to completion without preemption. The block sits between the round controller / key schedule and the shared S-box hardware, replacing per-requester S-box copies.

---
 rtl/aes_pkg.sv | 26 ++
 rtl/sbox.sv | 37 +++
 rtl/sbox_bank.sv | 23 ++
 rtl/sbox_share_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_sbox_share_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// ============================================================
// aes_pkg: shared AES S-box sharing types and sizes
// Revision: 1.0
// ============================================================
`default_nettype none

package aes_pkg;

  localparam int AES_STATE_BYTES = 16;
  localparam int AES_WORD_BYTES  = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN_STATE = 2'd1,
    RUN_KEY   = 2'd2,
    DONE      = 2'd3
  } fsm_state_t;

  typedef enum logic {
    OWNER_STATE = 1'b0,
    OWNER_KEY   = 1'b1
  } owner_t;

endpackage : aes_pkg

`default_nettype wire

// File: rtl/sbox.sv
// ============================================================
// SBox: combinational AES forward S-box, one byte in, one byte out
// Revision: 1.0
// ============================================================
`default_nettype none

module SBox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Row-major table, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry i occupies bits 8*(255-i)+7 downto 8*(255-i).
  assign dout = SBOX_TABLE[{~din, 3'b111} -: 8];

endmodule : SBox

`default_nettype wire

// File: rtl/sbox_bank.sv
// ============================================================
// sbox_bank: NUM_SBOX parallel combinational S-box lanes
// Revision: 1.0
// ============================================================
`default_nettype none

module sbox_bank #(
  parameter int NUM_SBOX = 4
) (
  input  logic [NUM_SBOX*8-1:0] din,
  output logic [NUM_SBOX*8-1:0] dout
);

  for (genvar j = 0; j < NUM_SBOX; j++) begin : g_lane
    SBox u_sbox (
      .din  (din[8*j +: 8]),
      .dout (dout[8*j +: 8])
    );
  end

endmodule : sbox_bank

`default_nettype wire

// File: rtl/sbox_share_ctrl.sv
// ============================================================
// sbox_share_ctrl: round-robin sharing of S-box lanes between SubBytes and SubWord jobs
// Revision: 1.0
// ============================================================
`default_nettype none

module sbox_share_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_SBOX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stateReq,
  input  logic [127:0] stateIn,
  output logic         stateGnt,
  output logic         stateDone,
  output logic [127:0] stateOut,
  input  logic         keyReq,
  input  logic [31:0]  keyWordIn,
  output logic         keyGnt,
  output logic         keyDone,
  output logic [31:0]  keyWordOut,
  output logic         busy
);

  localparam int STATE_CHUNKS = AES_STATE_BYTES / NUM_SBOX;
  localparam int KEY_CHUNKS   = AES_WORD_BYTES / NUM_SBOX;
  localparam int LANE_W       = NUM_SBOX * 8;
  localparam int CNT_W        = 4;
  localparam logic [CNT_W-1:0] STATE_LAST = CNT_W'(STATE_CHUNKS - 1);
  localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_CHUNKS - 1);

  if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4) begin : g_bad_num_sbox
    $error("sbox_share_ctrl: NUM_SBOX must be 1, 2 or 4");
  end

  fsm_state_t        state;
  fsm_state_t        next_state;
  owner_t            last_grant;
  owner_t            done_owner;
  logic [CNT_W-1:0]  chunk_cnt;
  logic [127:0]      work;
  logic [LANE_W-1:0] lane_in;
  logic [LANE_W-1:0] lane_out;
  logic [127:0]      state_next;
  logic [31:0]       key_next;
  logic              grant_state;
  logic              grant_key;
  logic              last_chunk;

  sbox_bank #(
    .NUM_SBOX (NUM_SBOX)
  ) u_sbox_bank (
    .din  (lane_in),
    .dout (lane_out)
  );

  // Lane j of chunk k handles byte k*NUM_SBOX+j of the work register.
  always_comb begin : p_lane_sel
    lane_in = '0;
    for (int b = 0; b < AES_STATE_BYTES; b++) begin
      if (CNT_W'(b / NUM_SBOX) == chunk_cnt) begin
        lane_in[8*(b % NUM_SBOX) +: 8] = work[8*b +: 8];
      end
    end
  end

  always_comb begin : p_merge
    state_next = stateOut;
    key_next   = keyWordOut;
    for (int b = 0; b < AES_STATE_BYTES; b++) begin
      if (CNT_W'(b / NUM_SBOX) == chunk_cnt) begin
        state_next[8*b +: 8] = lane_out[8*(b % NUM_SBOX) +: 8];
      end
    end
    for (int b = 0; b < AES_WORD_BYTES; b++) begin
      if (CNT_W'(b / NUM_SBOX) == chunk_cnt) begin
        key_next[8*b +: 8] = lane_out[8*(b % NUM_SBOX) +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_state_reg
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin : p_fsm_next
    next_state = state;
    case (state)
      IDLE: begin
        if (grant_state) begin
          next_state = RUN_STATE;
        end else if (grant_key) begin
          next_state = RUN_KEY;
        end
      end
      RUN_STATE, RUN_KEY: begin
        if (last_chunk) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // On a tie the requester not named by last_grant wins.
  always_comb begin : p_fsm_out
    grant_state = 1'b0;
    grant_key   = 1'b0;
    if (state == IDLE) begin
      if (stateReq && keyReq) begin
        grant_key   = (last_grant == OWNER_STATE);
        grant_state = (last_grant == OWNER_KEY);
      end else begin
        grant_state = stateReq;
        grant_key   = keyReq;
      end
    end
    last_chunk = ((state == RUN_STATE) && (chunk_cnt == STATE_LAST)) ||
                 ((state == RUN_KEY)   && (chunk_cnt == KEY_LAST));
    busy      = (state != IDLE);
    stateDone = (state == DONE) && (done_owner == OWNER_STATE);
    keyDone   = (state == DONE) && (done_owner == OWNER_KEY);
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_datapath
    if (!rst_n) begin
      chunk_cnt  <= '0;
      last_grant <= OWNER_STATE;
      done_owner <= OWNER_STATE;
      work       <= '0;
      stateOut   <= '0;
      keyWordOut <= '0;
      stateGnt   <= 1'b0;
      keyGnt     <= 1'b0;
    end else begin
      stateGnt <= 1'b0;
      keyGnt   <= 1'b0;
      case (state)
        IDLE: begin
          // last_grant only moves on a tie, so a lone request never shifts priority.
          if (stateReq && keyReq) begin
            last_grant <= grant_key ? OWNER_KEY : OWNER_STATE;
          end
          if (grant_state) begin
            work      <= stateIn;
            stateGnt  <= 1'b1;
            chunk_cnt <= '0;
          end else if (grant_key) begin
            work      <= {96'd0, keyWordIn};
            keyGnt    <= 1'b1;
            chunk_cnt <= '0;
          end
        end
        RUN_STATE: begin
          stateOut <= state_next;
          if (last_chunk) begin
            chunk_cnt  <= '0;
            done_owner <= OWNER_STATE;
          end else begin
            chunk_cnt <= chunk_cnt + 1'b1;
          end
        end
        RUN_KEY: begin
          keyWordOut <= key_next;
          if (last_chunk) begin
            chunk_cnt  <= '0;
            done_owner <= OWNER_KEY;
          end else begin
            chunk_cnt <= chunk_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : sbox_share_ctrl

`default_nettype wire

// File: tb/tb_sbox_share_ctrl.sv
// ============================================================
// tb_sbox_share_ctrl: directed checks of S-box sharing with 4 lanes and 1 lane
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_sbox_share_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst4_n = 1'b0;
  logic         s4_req = 1'b0, k4_req = 1'b0;
  logic [127:0] s4_in = '0;
  logic [31:0]  k4_in = '0;
  logic         s4_gnt, s4_done, k4_gnt, k4_done, busy4;
  logic [127:0] s4_out;
  logic [31:0]  k4_out;

  logic         rst1_n = 1'b0;
  logic         s1_req = 1'b0, k1_req = 1'b0;
  logic [127:0] s1_in = '0;
  logic [31:0]  k1_in = '0;
  logic         s1_gnt, s1_done, k1_gnt, k1_done, busy1;
  logic [127:0] s1_out;
  logic [31:0]  k1_out;

  int checks = 0;
  int failures = 0;

  sbox_share_ctrl #(.NUM_SBOX(4)) u_dut4 (
    .clk(clk), .rst_n(rst4_n),
    .stateReq(s4_req), .stateIn(s4_in), .stateGnt(s4_gnt), .stateDone(s4_done), .stateOut(s4_out),
    .keyReq(k4_req), .keyWordIn(k4_in), .keyGnt(k4_gnt), .keyDone(k4_done), .keyWordOut(k4_out),
    .busy(busy4)
  );

  sbox_share_ctrl #(.NUM_SBOX(1)) u_dut1 (
    .clk(clk), .rst_n(rst1_n),
    .stateReq(s1_req), .stateIn(s1_in), .stateGnt(s1_gnt), .stateDone(s1_done), .stateOut(s1_out),
    .keyReq(k1_req), .keyWordIn(k1_in), .keyGnt(k1_gnt), .keyDone(k1_done), .keyWordOut(k1_out),
    .busy(busy1)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles from the grant cycle until the selected Done is seen; -1 on timeout.
  task automatic wait_done(input int which, output int cycles);
    logic seen;
    cycles = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      case (which)
        0:       seen = s4_done;
        1:       seen = k4_done;
        2:       seen = s1_done;
        default: seen = k1_done;
      endcase
      if (seen) begin
        cycles = n;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int busy_cnt;
    int done_at;
    logic seen;
    logic [127:0] result;

    repeat (2) tick();
    check("reset_state_out", s4_out, '0);
    check("reset_key_out", k4_out, '0);
    check("reset_ctrl4", {s4_gnt, k4_gnt, s4_done, k4_done, busy4}, '0);
    check("reset_ctrl1", {s1_gnt, k1_gnt, s1_done, k1_done, busy1, s1_out}, '0);
    rst4_n = 1'b1;
    rst1_n = 1'b1;
    tick();

    // SubBytes of all-zero state
    s4_in = '0; s4_req = 1'b1;
    tick();
    check("st_gnt", {s4_gnt, k4_gnt}, 2'b10);
    s4_req = 1'b0;
    wait_done(0, n);
    check("st_latency", n, 4);
    check("st_out", s4_out, {16{8'h63}});
    check("st_key_untouched", k4_out, '0);
    tick();
    check("st_back_idle", {busy4, s4_done}, 2'b00);

    // SubWord
    k4_in = 32'h03020100; k4_req = 1'b1;
    tick();
    check("key_gnt", {s4_gnt, k4_gnt}, 2'b01);
    k4_req = 1'b0;
    wait_done(1, n);
    check("key_latency", n, 1);
    check("key_out", k4_out, 32'h7b777c63);
    check("key_state_kept", s4_out, {16{8'h63}});
    tick();

    // Tie after reset: key wins, state stays pending
    s4_in = {16{8'h01}}; k4_in = 32'h53535353;
    s4_req = 1'b1; k4_req = 1'b1;
    tick();
    check("tie_key_first", {s4_gnt, k4_gnt}, 2'b01);
    k4_req = 1'b0;
    wait_done(1, n);
    check("tie_key_out", k4_out, 32'hedededed);
    tick();
    tick();
    check("tie_state_next", {s4_gnt, k4_gnt}, 2'b10);
    s4_req = 1'b0;
    wait_done(0, n);
    check("tie_state_out", s4_out, {16{8'h7c}});
    tick();

    // Held keyReq: back-to-back key jobs, then state wins the next tie
    k4_in = '0; k4_req = 1'b1;
    tick();
    check("b2b_gnt0", {s4_gnt, k4_gnt}, 2'b01);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (k4_gnt) begin
        n = i;
        break;
      end
    end
    check("b2b_spacing", n, 3);
    check("b2b_key_out", k4_out, 32'h63636363);
    s4_in = {16{8'h10}}; s4_req = 1'b1;
    tick();
    check("b2b_done_no_gnt", {s4_gnt, k4_gnt, k4_done}, 3'b001);
    tick();
    tick();
    check("b2b_state_wins", {s4_gnt, k4_gnt}, 2'b10);
    s4_req = 1'b0;
    wait_done(0, n);
    check("b2b_state_out", s4_out, {16{8'hca}});
    tick();
    tick();
    check("b2b_key_resumes", {s4_gnt, k4_gnt}, 2'b01);
    k4_req = 1'b0;
    wait_done(1, n);
    tick();

    // Reset while RUN_STATE is at chunk 2
    s4_in = {16{8'h53}}; s4_req = 1'b1;
    tick();
    s4_req = 1'b0;
    tick();
    tick();
    check("mid_busy", busy4, 1'b1);
    rst4_n = 1'b0;
    #1;
    check("mid_rst_state_out", s4_out, '0);
    check("mid_rst_key_out", k4_out, '0);
    check("mid_rst_busy", busy4, 1'b0);
    seen = 1'b0;
    tick();
    rst4_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s4_done) seen = 1'b1;
    end
    check("mid_rst_no_done", seen, 1'b0);
    s4_in = '0; s4_req = 1'b1;
    tick();
    check("rerun_gnt", {s4_gnt, k4_gnt}, 2'b10);
    s4_req = 1'b0;
    wait_done(0, n);
    check("rerun_out", s4_out, {16{8'h63}});
    check("rerun_key_clear", k4_out, '0);

    // Single lane: 16 chunks, input changed after capture
    s1_in = {16{8'h53}}; s1_req = 1'b1;
    tick();
    check("n1_gnt", {s1_gnt, k1_gnt}, 2'b10);
    s1_req = 1'b0;
    s1_in = {16{8'hff}};
    busy_cnt = 0; done_at = -1; result = '0;
    for (int i = 0; i < 40; i++) begin
      if (!busy1) break;
      busy_cnt++;
      if (s1_done) begin
        done_at = busy_cnt;
        result = s1_out;
      end
      tick();
    end
    check("n1_busy_cycles", busy_cnt, 17);
    check("n1_done_at", done_at, 17);
    check("n1_state_out", result, {16{8'hed}});
    k1_in = 32'h03020100; k1_req = 1'b1;
    tick();
    check("n1_key_gnt", {s1_gnt, k1_gnt}, 2'b01);
    k1_req = 1'b0;
    wait_done(3, n);
    check("n1_key_latency", n, 4);
    check("n1_key_out", k1_out, 32'h7b777c63);
    check("n1_state_kept", s1_out, {16{8'hed}});
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sbox_share_ctrl

`default_nettype wire
